// File: rtl/melody_sequencer_pkg.sv
// Shared definitions for the melody sequencer and the tone generator.
//   - ROM entry layout (rest/octave/note/dur) and field widths
//   - sequencer state encoding
//   - dur code -> beat tick count (1,2,4,8)
package melody_sequencer_pkg;
  localparam int NOTE_W = 4;
  localparam int OCT_W  = 3;
  localparam int DUR_W  = 2;
  localparam int ADDR_W = 4;
  localparam int ROM_W  = 10;

  localparam int REST_BIT = 9;
  localparam int OCT_LSB  = 6;
  localparam int NOTE_LSB = 2;
  localparam int DUR_LSB  = 0;

  // Note codes at or above this value play as silence.
  localparam logic [NOTE_W-1:0] NOTE_REST_MIN = 4'd12;

  // Field order matches bit positions REST_BIT..DUR_LSB.
  typedef struct packed {
    logic              rest;
    logic [OCT_W-1:0]  octave;
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } rom_entry_t;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PLAY, S_GAP} state_t;

  function automatic logic [3:0] dur_ticks(input logic [DUR_W-1:0] d);
    case (d)
      2'd0:    dur_ticks = 4'd1;
      2'd1:    dur_ticks = 4'd2;
      2'd2:    dur_ticks = 4'd4;
      default: dur_ticks = 4'd8;
    endcase
  endfunction
endpackage

// File: rtl/melody_sequencer_if.sv
// Control/tone bundle between top-level control (master) and the
// sequencer (slave). Outputs of the sequencer feed the tone generator.
interface melody_sequencer_if;
  import melody_sequencer_pkg::*;
  logic              start;
  logic              stop;
  logic              loop_en;
  logic [NOTE_W-1:0] note;
  logic [OCT_W-1:0]  octave;
  logic              tone_en;
  logic              note_start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] index;

  modport master (output start, stop, loop_en,
                  input  note, octave, tone_en, note_start, busy, done, index);
  modport slave  (input  start, stop, loop_en,
                  output note, octave, tone_en, note_start, busy, done, index);
endinterface

// File: rtl/melody_sequencer_rom.sv
// melody_rom: combinational melody table.
//   addr : entry index
//   data : {rest, octave, note, dur}; unused addresses are a dur-0 rest
module melody_rom
  import melody_sequencer_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  output rom_entry_t        data
);
  always_comb begin
    data = '{rest: 1'b1, octave: '0, note: '0, dur: 2'd0};
    case (addr)
      4'd0: data = '{rest: 1'b0, octave: 3'd2, note: 4'd0,  dur: 2'd1};
      4'd1: data = '{rest: 1'b0, octave: 3'd2, note: 4'd4,  dur: 2'd0};
      4'd2: data = '{rest: 1'b0, octave: 3'd2, note: 4'd7,  dur: 2'd0};
      4'd3: data = '{rest: 1'b1, octave: 3'd0, note: 4'd0,  dur: 2'd0};
      4'd4: data = '{rest: 1'b0, octave: 3'd2, note: 4'd11, dur: 2'd2};
      4'd5: data = '{rest: 1'b0, octave: 3'd3, note: 4'd0,  dur: 2'd0};
      4'd6: data = '{rest: 1'b0, octave: 3'd1, note: 4'd9,  dur: 2'd3};
      4'd7: data = '{rest: 1'b0, octave: 3'd0, note: 4'd12, dur: 2'd0};
      default: ;
    endcase
  end
endmodule

// File: rtl/melody_sequencer.sv
// melody_sequencer: steps the tone generator through the melody ROM.
//   clk, rst : clock, async active-high reset
//   bus      : start/stop/loop_en in; note/octave/tone_en/note_start/
//              busy/done/index out
// Each entry: FETCH (1) + PLAY (ticks*TICK_DIV) + GAP (GAP_CYCLES).
module melody_sequencer
  import melody_sequencer_pkg::*;
#(
  parameter int TICK_DIV   = 4,
  parameter int GAP_CYCLES = 2,
  parameter int SONG_LEN   = 8
) (
  input  logic               clk,
  input  logic               rst,
  melody_sequencer_if.slave  bus
);
  localparam int PRE_W = $clog2(TICK_DIV);
  localparam int GAP_W = $clog2(GAP_CYCLES) + 1;

  state_t           state, nxt;
  rom_entry_t       rom_q;
  logic [PRE_W-1:0] pre;
  logic [2:0]       tcnt;
  logic [GAP_W-1:0] gcnt;
  logic [DUR_W-1:0] dur_q;
  logic             pre_wrap, play_end, gap_end, last_entry;

  melody_rom u_rom (.addr(bus.index), .data(rom_q));

  assign pre_wrap   = (pre == PRE_W'(TICK_DIV - 1));
  assign play_end   = pre_wrap && ({1'b0, tcnt} == dur_ticks(dur_q) - 4'd1);
  assign gap_end    = (gcnt == GAP_W'(GAP_CYCLES - 1));
  assign last_entry = (bus.index == ADDR_W'(SONG_LEN - 1));
  assign bus.busy   = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else     state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (bus.start && !bus.stop) nxt = S_FETCH;
      S_FETCH: nxt = S_PLAY;
      S_PLAY:  if (play_end) nxt = S_GAP;
      S_GAP:   if (gap_end) nxt = (!last_entry || bus.loop_en) ? S_FETCH : S_IDLE;
      default: nxt = S_IDLE;
    endcase
    // stop overrides every transition out of a busy state
    if (bus.stop && state != S_IDLE) nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.note       <= '0;
      bus.octave     <= '0;
      bus.tone_en    <= 1'b0;
      bus.note_start <= 1'b0;
      bus.done       <= 1'b0;
      bus.index      <= '0;
      dur_q          <= '0;
      pre            <= '0;
      tcnt           <= '0;
      gcnt           <= '0;
    end else begin
      bus.note_start <= 1'b0;
      bus.done       <= 1'b0;
      if (bus.stop && state != S_IDLE) begin
        bus.tone_en <= 1'b0;
        bus.index   <= '0;
        pre         <= '0;
        tcnt        <= '0;
        gcnt        <= '0;
      end else begin
        case (state)
          S_IDLE: if (bus.start && !bus.stop) bus.index <= '0;
          S_FETCH: begin
            bus.note       <= rom_q.note;
            bus.octave     <= rom_q.octave;
            dur_q          <= rom_q.dur;
            bus.tone_en    <= !rom_q.rest && (rom_q.note < NOTE_REST_MIN);
            bus.note_start <= 1'b1;
            pre            <= '0;
            tcnt           <= '0;
          end
          S_PLAY: begin
            if (play_end) begin
              bus.tone_en <= 1'b0;
              gcnt        <= '0;
            end else if (pre_wrap) begin
              pre  <= '0;
              tcnt <= tcnt + 3'd1;
            end else begin
              pre <= pre + PRE_W'(1);
            end
          end
          S_GAP: begin
            if (gap_end) begin
              if (!last_entry)      bus.index <= bus.index + 4'd1;
              else if (bus.loop_en) bus.index <= '0;
              else                  bus.done  <= 1'b1;
            end else begin
              gcnt <= gcnt + GAP_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
Sequences the square-wave tone generator through a fixed melody held in a small ROM. For each entry it presents note, octave and a tone enable, holds them for a programmed number of beat ticks, then inserts a short silent articulation gap. Supports start, stop and loop. Sits between top-level control and the tone generator, replacing free-running counter-driven note selection.

Parameters:
TICK_DIV, 4, clock cycles per beat tick (>=2; silicon value is much larger, small for simulation)
GAP_CYCLES, 2, silent cycles after every entry (>=1)
SONG_LEN, 8, ROM entries played, 1..16

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
start  in  1  level-sampled; begins playback from entry 0 when idle
stop  in  1  level-sampled; aborts playback
loop_en  in  1  wrap to entry 0 after the last entry instead of finishing
note  out  4  semitone index 0..11 to the tone generator
octave  out  3  octave 0..5 to the tone generator
tone_en  out  1  tone generator output gate
note_start  out  1  one-cycle pulse on the first PLAY cycle of each entry
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when a non-looping song completes
index  out  4  current ROM entry

Behaviour:
- Reset (async, active-high): state IDLE; note=0, octave=0, tone_en=0, note_start=0, busy=0, done=0, index=0; prescaler and duration counters =0.
- ROM entry, 10 bits: [9] rest, [8:6] octave, [5:2] note, [1:0] dur. Duration in ticks = 1,2,4,8 for dur 0..3. Note 12..15 is treated as rest.
- States: IDLE, FETCH, PLAY, GAP.
- IDLE: start=1 and stop=0 -> FETCH with index=0.
- FETCH (1 cycle): ROM is read at index, and the entry is registered into note/octave/dur. tone_en = ~rest. Next state is PLAY. Outputs are valid on the first PLAY cycle, 2 cycles after start is sampled.
- PLAY: lasts exactly ticks(dur)*TICK_DIV cycles. The prescaler clears on entry. note_start=1 on the first cycle only. Next state is GAP.
- GAP: lasts GAP_CYCLES cycles. tone_en=0; note and octave hold. At the end:
  - if index < SONG_LEN-1: index+1 -> FETCH;
  - else if loop_en: index=0 -> FETCH;
  - else: -> IDLE with done=1 for one cycle.
- Period per entry = 1 + ticks*TICK_DIV + GAP_CYCLES cycles.
- stop=1 in any non-IDLE state: next cycle is IDLE, tone_en=0, index=0, and no done pulse. stop has priority over start and over every state transition.
- start while busy is ignored. start held high in IDLE retriggers immediately after done.
- loop_en is sampled only at the end of the last GAP.
- Counter widths are sized from the parameters. Counters never wrap inside a state.

Default ROM contents (note/octave/dur/rest):
- 0: 0/2/1/0
- 1: 4/2/0/0
- 2: 7/2/0/0
- 3: x/x/0/1
- 4: 11/2/2/0
- 5: 0/3/0/0
- 6: 9/1/3/0
- 7: 12/0/0/0 (rest by note code)

Decomposition:
- Shared package: ROM field positions, the state encoding, and the dur-to-ticks constants (1,2,4,8). The tone generator reuses the note and octave widths from the same package.
- One sub-module: melody_rom, a combinational case table indexed by 4-bit address; unused addresses return a rest of dur 0.

Test Plan:
1. Reset mid-PLAY (rst pulse asynchronous to clk) -> all outputs 0 immediately, state IDLE; start afterwards plays from entry 0.
2. start one cycle, loop_en=0, defaults (TICK_DIV=4, GAP_CYCLES=2) -> entry 0 note=0/octave=2/tone_en=1 from cycle 2 for 8 cycles, then tone_en=0 for 2 cycles. Entry 3 and entry 7 have tone_en=0 in PLAY. Exactly 8 note_start pulses. done pulses once at cycle 1+Σ(1+ticks*4+2)=1+4*? computed by the bench model. busy then falls.
3. Entry 6 (dur 3) -> tone_en high for exactly 32 cycles with note=9, octave=1.
4. loop_en=1 -> after entry 7's gap, index=0 and note_start fires with note=0; no done pulse. Run 3 loops and check each loop has identical timing.
5. stop asserted during entry 4 PLAY -> next cycle tone_en=0, busy=0, index=0, no done. start and stop together in IDLE -> remains IDLE.
6. start pulsed during PLAY -> ignored; sequence timing unchanged versus scenario 2.
